// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the stage-5 stack-CPU control sequencer.
//   state_e : sequencer micro-op states
//   Op*     : instruction opcodes (IR[15:12])
//   *Sel    : datapath mux select encodings
//   ctrl_t  : control vector produced by stage5_control_decode
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    StRst,
    StFetch,
    StDecode,
    StPopADec,
    StPopARd,
    StPopBDec,
    StPopBRd,
    StAluEx,
    StPushRes,
    StPushImm,
    StJump,
    StBrTest,
    StCallWr,
    StRspDec,
    StRspRd,
    StRetJmp,
    StHalt
  } state_e;

  // Opcodes
  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpPushi = 4'h1;
  localparam logic [3:0] OpAlu   = 4'h2;
  localparam logic [3:0] OpJmp   = 4'h3;
  localparam logic [3:0] OpBz    = 4'h4;
  localparam logic [3:0] OpCall  = 4'h5;
  localparam logic [3:0] OpRet   = 4'h6;
  localparam logic [3:0] OpHalt  = 4'hF;

  // Memory port 1 address select
  localparam logic [1:0] MemDst1PcSel  = 2'd0;
  localparam logic [1:0] MemDst1MspSel = 2'd1;
  // Memory port 2 address select
  localparam logic [1:0] MemDst2MspSel = 2'd0;
  localparam logic [1:0] MemDst2RspSel = 2'd1;
  // Memory write data select
  localparam logic [1:0] MemDataPcSel  = 2'd0;
  localparam logic [1:0] MemDataResSel = 2'd1;
  localparam logic [1:0] MemDataImmSel = 2'd2;
  // PC next-value source and adder operand
  localparam logic PcSourceAdderSel = 1'b0;
  localparam logic PcSourceValASel  = 1'b1;
  localparam logic PcAddOneSel      = 1'b0;
  localparam logic PcAddOffsetSel   = 1'b1;

  typedef struct packed {
    logic       pc_reg_reset;
    logic       msp_reg_reset;
    logic       rsp_reg_reset;
    logic       pc_write;
    logic       pc_source;
    logic       pc_add;
    logic       msp_write;
    logic       msp_pop;
    logic       rsp_write;
    logic       rsp_pop;
    logic       val_a_write;
    logic       val_b_write;
    logic       ir_write;
    logic       mem_read1;
    logic       mem_read2;
    logic       mem_write1;
    logic       mem_write2;
    logic [1:0] mem_dst1;
    logic [1:0] mem_dst2;
    logic [1:0] mem_data;
    logic       res_write;
    logic       halted;
  } ctrl_t;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= 4'h7) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/stage5_control_decode.sv
// Combinational micro-op decode: maps the sequencer state (plus ValA for the
// branch test and IR for the ALU function) to the datapath control vector.
//   state_i  : current sequencer state
//   ir_i     : instruction register
//   val_a_i  : ValA register, tested in StBrTest
//   ctrl_o   : control vector (unlisted fields are 0)
//   alu_op_o : ALU function, IR[2:0]
module stage5_control_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [15:0] ir_i,
  input  logic [15:0] val_a_i,
  output ctrl_t       ctrl_o,
  output logic [2:0]  alu_op_o
);

  logic unused_ir;
  assign unused_ir = ^ir_i[15:3];

  assign alu_op_o = ir_i[2:0];

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StRst: begin
        ctrl_o.pc_reg_reset  = 1'b1;
        ctrl_o.msp_reg_reset = 1'b1;
        ctrl_o.rsp_reg_reset = 1'b1;
      end
      StFetch: begin
        ctrl_o.mem_read1 = 1'b1;
        ctrl_o.mem_dst1  = MemDst1PcSel;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PcSourceAdderSel;
        ctrl_o.pc_add    = PcAddOneSel;
      end
      StDecode: ;
      StPopADec, StPopBDec: begin
        ctrl_o.msp_write = 1'b1;
        ctrl_o.msp_pop   = 1'b1;
      end
      StPopARd: begin
        ctrl_o.mem_read2   = 1'b1;
        ctrl_o.mem_dst2    = MemDst2MspSel;
        ctrl_o.val_a_write = 1'b1;
      end
      StPopBRd: begin
        ctrl_o.mem_read2   = 1'b1;
        ctrl_o.mem_dst2    = MemDst2MspSel;
        ctrl_o.val_b_write = 1'b1;
      end
      StAluEx: ctrl_o.res_write = 1'b1;
      StPushRes, StPushImm: begin
        ctrl_o.mem_write2 = 1'b1;
        ctrl_o.mem_dst2   = MemDst2MspSel;
        ctrl_o.mem_data   = (state_i == StPushRes) ? MemDataResSel : MemDataImmSel;
        ctrl_o.msp_write  = 1'b1;
        ctrl_o.msp_pop    = 1'b0;
      end
      StJump: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PcSourceAdderSel;
        ctrl_o.pc_add    = PcAddOffsetSel;
      end
      StBrTest: begin
        // ValA was loaded at the previous edge, so it is valid here
        if (val_a_i == 16'h0000) begin
          ctrl_o.pc_write = 1'b1;
          ctrl_o.pc_add   = PcAddOffsetSel;
        end
      end
      StCallWr: begin
        // PC still holds the return address during this cycle
        ctrl_o.mem_write2 = 1'b1;
        ctrl_o.mem_dst2   = MemDst2RspSel;
        ctrl_o.mem_data   = MemDataPcSel;
        ctrl_o.rsp_write  = 1'b1;
        ctrl_o.rsp_pop    = 1'b0;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_add     = PcAddOffsetSel;
      end
      StRspDec: begin
        ctrl_o.rsp_write = 1'b1;
        ctrl_o.rsp_pop   = 1'b1;
      end
      StRspRd: begin
        ctrl_o.mem_read2   = 1'b1;
        ctrl_o.mem_dst2    = MemDst2RspSel;
        ctrl_o.val_a_write = 1'b1;
      end
      StRetJmp: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PcSourceValASel;
      end
      StHalt: ctrl_o.halted = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/stage5_control_sequencer.sv
// Multi-cycle Moore control sequencer for the stage-5 stack-CPU datapath.
// Holds the state register and next-state logic; per-state outputs come from
// stage5_control_decode. While RegReset is high every read/write/push enable
// is forced low so an aborted instruction leaves no partial memory/SP update.
//   CLK, RegReset         : clock, synchronous active-high reset
//   IR, ValA              : instruction register, branch-test operand
//   *RegReset             : datapath register resets (high in RST)
//   PC*/MSP*/RSP*         : PC and stack-pointer control
//   ValAWrite..IRWrite    : register loads
//   MemRead*/MemWrite*    : memory port enables; MemDst*/MemData selects
//   ResWrite, AluOp       : ALU result load and function (IR[2:0])
//   Halted                : high in HALT
// Optional feature macro ILLEGAL_TRAP_EN: opcodes 7-E trap to HALT and the
// IllegalOp output is added; otherwise they execute as NOP.
module stage5_control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RegReset,
  input  logic [15:0] IR,
  input  logic [15:0] ValA,
  output logic        PCRegReset,
  output logic        MSPRegReset,
  output logic        RSPRegReset,
  output logic        PCWrite,
  output logic        PCSource,
  output logic        PCAdd,
  output logic        MSPWrite,
  output logic        MSPPop,
  output logic        RSPWrite,
  output logic        RSPPop,
  output logic        ValAWrite,
  output logic        ValBWrite,
  output logic        IRWrite,
  output logic        MemRead1,
  output logic        MemRead2,
  output logic        MemWrite1,
  output logic        MemWrite2,
  output logic [1:0]  MemDst1,
  output logic [1:0]  MemDst2,
  output logic [1:0]  MemData,
  output logic        ResWrite,
  output logic [2:0]  AluOp,
  output logic        Halted
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic        IllegalOp
`endif
);

  state_e      state_q;
  ctrl_t       dec_ctrl;
  ctrl_t       ctrl;
  logic [3:0]  opcode;

  assign opcode = IR[15:12];

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign IllegalOp = illegal_q;
`endif

  always_ff @(posedge CLK) begin
    if (RegReset) begin
      state_q <= StRst;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StRst:   state_q <= StFetch;
        StFetch: state_q <= StDecode;
        StDecode: begin
          case (opcode)
            OpNop:   state_q <= StFetch;
            OpPushi: state_q <= StPushImm;
            OpAlu:   state_q <= StPopADec;
            OpJmp:   state_q <= StJump;
            OpBz:    state_q <= StPopADec;
            OpCall:  state_q <= StCallWr;
            OpRet:   state_q <= StRspDec;
            OpHalt:  state_q <= StHalt;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state_q <= StHalt;
              if (is_illegal_op(opcode)) illegal_q <= 1'b1;
`else
              state_q <= StFetch;
`endif
            end
          endcase
        end
        StPopADec: state_q <= StPopARd;
        // BZ and ALU share the first pop; IR is stable for the whole sequence
        StPopARd:  state_q <= (opcode == OpBz) ? StBrTest : StPopBDec;
        StPopBDec: state_q <= StPopBRd;
        StPopBRd:  state_q <= StAluEx;
        StAluEx:   state_q <= StPushRes;
        StRspDec:  state_q <= StRspRd;
        StRspRd:   state_q <= StRetJmp;
        StPushRes, StPushImm, StJump, StBrTest, StCallWr, StRetJmp: state_q <= StFetch;
        StHalt:    state_q <= StHalt;
        default:   state_q <= StRst;
      endcase
    end
  end

  stage5_control_decode u_decode (
    .state_i  (state_q),
    .ir_i     (IR),
    .val_a_i  (ValA),
    .ctrl_o   (dec_ctrl),
    .alu_op_o (AluOp)
  );

  always_comb begin
    ctrl = dec_ctrl;
    if (RegReset) begin
      ctrl.pc_write    = 1'b0;
      ctrl.msp_write   = 1'b0;
      ctrl.rsp_write   = 1'b0;
      ctrl.val_a_write = 1'b0;
      ctrl.val_b_write = 1'b0;
      ctrl.ir_write    = 1'b0;
      ctrl.mem_read1   = 1'b0;
      ctrl.mem_read2   = 1'b0;
      ctrl.mem_write1  = 1'b0;
      ctrl.mem_write2  = 1'b0;
      ctrl.res_write   = 1'b0;
    end
  end

  assign PCRegReset  = ctrl.pc_reg_reset;
  assign MSPRegReset = ctrl.msp_reg_reset;
  assign RSPRegReset = ctrl.rsp_reg_reset;
  assign PCWrite     = ctrl.pc_write;
  assign PCSource    = ctrl.pc_source;
  assign PCAdd       = ctrl.pc_add;
  assign MSPWrite    = ctrl.msp_write;
  assign MSPPop      = ctrl.msp_pop;
  assign RSPWrite    = ctrl.rsp_write;
  assign RSPPop      = ctrl.rsp_pop;
  assign ValAWrite   = ctrl.val_a_write;
  assign ValBWrite   = ctrl.val_b_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemRead1    = ctrl.mem_read1;
  assign MemRead2    = ctrl.mem_read2;
  assign MemWrite1   = ctrl.mem_write1;
  assign MemWrite2   = ctrl.mem_write2;
  assign MemDst1     = ctrl.mem_dst1;
  assign MemDst2     = ctrl.mem_dst2;
  assign MemData     = ctrl.mem_data;
  assign ResWrite    = ctrl.res_write;
  assign Halted      = ctrl.halted;

endmodule

// File: tb/tb_stage5_control_sequencer.sv
// Scoreboard bench for stage5_control_sequencer: each stimulus cycle pushes
// its hand-written expected control vector; a monitor pops and compares on
// the falling edge.
module tb_stage5_control_sequencer;

  typedef struct packed {
    logic       pc_rr, msp_rr, rsp_rr;
    logic       pc_write, pc_source, pc_add;
    logic       msp_write, msp_pop, rsp_write, rsp_pop;
    logic       vala_write, valb_write, ir_write;
    logic       mem_read1, mem_read2, mem_write1, mem_write2;
    logic [1:0] mem_dst1, mem_dst2, mem_data;
    logic       res_write;
    logic [2:0] alu_op;
    logic       halted;
    logic       illegal;
  } tb_ctl_t;

  logic        CLK = 1'b0;
  logic        RegReset = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic [15:0] ValA = 16'h0000;
  logic        PCRegReset, MSPRegReset, RSPRegReset, PCWrite, PCSource, PCAdd;
  logic        MSPWrite, MSPPop, RSPWrite, RSPPop, ValAWrite, ValBWrite, IRWrite;
  logic        MemRead1, MemRead2, MemWrite1, MemWrite2, ResWrite, Halted;
  logic [1:0]  MemDst1, MemDst2, MemData;
  logic [2:0]  AluOp;
  logic        illegal_act;

  tb_ctl_t     exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 CLK = ~CLK;

  stage5_control_sequencer dut (
    .CLK(CLK), .RegReset(RegReset), .IR(IR), .ValA(ValA),
    .PCRegReset(PCRegReset), .MSPRegReset(MSPRegReset), .RSPRegReset(RSPRegReset),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
    .MSPWrite(MSPWrite), .MSPPop(MSPPop), .RSPWrite(RSPWrite), .RSPPop(RSPPop),
    .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
    .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
    .ResWrite(ResWrite), .AluOp(AluOp), .Halted(Halted)
`ifdef ILLEGAL_TRAP_EN
    , .IllegalOp(illegal_act)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign illegal_act = 1'b0;
`endif

  // Expected per-state vectors, written from the micro-op table
  function automatic tb_ctl_t e_zero();
    tb_ctl_t e = '0;
    return e;
  endfunction
  function automatic tb_ctl_t e_rst();
    tb_ctl_t e = '0;
    e.pc_rr = 1; e.msp_rr = 1; e.rsp_rr = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_fetch();
    tb_ctl_t e = '0;
    e.mem_read1 = 1; e.ir_write = 1; e.pc_write = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_msp_pop();
    tb_ctl_t e = '0;
    e.msp_write = 1; e.msp_pop = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_rd(input logic b);
    tb_ctl_t e = '0;
    e.mem_read2 = 1;
    if (b) e.valb_write = 1;
    else   e.vala_write = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_push(input logic [1:0] data);
    tb_ctl_t e = '0;
    e.mem_write2 = 1; e.mem_data = data; e.msp_write = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_alu();
    tb_ctl_t e = '0;
    e.res_write = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_branch();
    tb_ctl_t e = '0;
    e.pc_write = 1; e.pc_add = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_call();
    tb_ctl_t e = '0;
    e.mem_write2 = 1; e.mem_dst2 = 2'd1; e.rsp_write = 1; e.pc_write = 1; e.pc_add = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_rsp_dec();
    tb_ctl_t e = '0;
    e.rsp_write = 1; e.rsp_pop = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_rsp_rd();
    tb_ctl_t e = '0;
    e.mem_read2 = 1; e.mem_dst2 = 2'd1; e.vala_write = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_ret();
    tb_ctl_t e = '0;
    e.pc_write = 1; e.pc_source = 1;
    return e;
  endfunction
  function automatic tb_ctl_t e_halt(input logic ill);
    tb_ctl_t e = '0;
    e.halted = 1; e.illegal = ill;
    return e;
  endfunction

  task automatic cyc(input string nm, input logic rst, input logic [15:0] ir,
                     input logic [15:0] va, input tb_ctl_t e);
    @(posedge CLK);
    #1;
    RegReset = rst;
    IR = ir;
    ValA = va;
    e.alu_op = ir[2:0];
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    tb_ctl_t e;
    tb_ctl_t a;
    string   nm;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a = '{PCRegReset, MSPRegReset, RSPRegReset, PCWrite, PCSource, PCAdd,
              MSPWrite, MSPPop, RSPWrite, RSPPop, ValAWrite, ValBWrite, IRWrite,
              MemRead1, MemRead2, MemWrite1, MemWrite2, MemDst1, MemDst2, MemData,
              ResWrite, AluOp, Halted, illegal_act};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", nm, a, e);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset held for two cycles, then one RST cycle, then FETCH
    cyc("rst_hold", 1'b1, 16'h0000, 16'h0000, e_rst());
    cyc("rst_state", 1'b0, 16'h0000, 16'h0000, e_rst());
    // PUSHI
    cyc("pushi_fetch", 1'b0, 16'h1005, 16'h0000, e_fetch());
    cyc("pushi_decode", 1'b0, 16'h1005, 16'h0000, e_zero());
    cyc("pushi_push", 1'b0, 16'h1005, 16'h0000, e_push(2'd2));
    // ALU
    cyc("alu_fetch", 1'b0, 16'h2003, 16'h0000, e_fetch());
    cyc("alu_decode", 1'b0, 16'h2003, 16'h0000, e_zero());
    cyc("alu_popa_dec", 1'b0, 16'h2003, 16'h0000, e_msp_pop());
    cyc("alu_popa_rd", 1'b0, 16'h2003, 16'h0000, e_rd(1'b0));
    cyc("alu_popb_dec", 1'b0, 16'h2003, 16'h0000, e_msp_pop());
    cyc("alu_popb_rd", 1'b0, 16'h2003, 16'h0000, e_rd(1'b1));
    cyc("alu_ex", 1'b0, 16'h2003, 16'h0000, e_alu());
    cyc("alu_push_res", 1'b0, 16'h2003, 16'h0000, e_push(2'd1));
    // JMP
    cyc("jmp_fetch", 1'b0, 16'h3004, 16'h0000, e_fetch());
    cyc("jmp_decode", 1'b0, 16'h3004, 16'h0000, e_zero());
    cyc("jmp_jump", 1'b0, 16'h3004, 16'h0000, e_branch());
    // NOP
    cyc("nop_fetch", 1'b0, 16'h0000, 16'h0000, e_fetch());
    cyc("nop_decode", 1'b0, 16'h0000, 16'h0000, e_zero());
    // BZ taken (ValA == 0)
    cyc("bz0_fetch", 1'b0, 16'h4FFE, 16'h0000, e_fetch());
    cyc("bz0_decode", 1'b0, 16'h4FFE, 16'h0000, e_zero());
    cyc("bz0_pop_dec", 1'b0, 16'h4FFE, 16'h0000, e_msp_pop());
    cyc("bz0_pop_rd", 1'b0, 16'h4FFE, 16'h0000, e_rd(1'b0));
    cyc("bz0_test", 1'b0, 16'h4FFE, 16'h0000, e_branch());
    // BZ not taken (ValA == 1)
    cyc("bz1_fetch", 1'b0, 16'h4FFE, 16'h0001, e_fetch());
    cyc("bz1_decode", 1'b0, 16'h4FFE, 16'h0001, e_zero());
    cyc("bz1_pop_dec", 1'b0, 16'h4FFE, 16'h0001, e_msp_pop());
    cyc("bz1_pop_rd", 1'b0, 16'h4FFE, 16'h0001, e_rd(1'b0));
    cyc("bz1_test", 1'b0, 16'h4FFE, 16'h0001, e_zero());
    // CALL then RET
    cyc("call_fetch", 1'b0, 16'h5010, 16'h0000, e_fetch());
    cyc("call_decode", 1'b0, 16'h5010, 16'h0000, e_zero());
    cyc("call_wr", 1'b0, 16'h5010, 16'h0000, e_call());
    cyc("ret_fetch", 1'b0, 16'h6000, 16'h0000, e_fetch());
    cyc("ret_decode", 1'b0, 16'h6000, 16'h0000, e_zero());
    cyc("ret_rsp_dec", 1'b0, 16'h6000, 16'h0000, e_rsp_dec());
    cyc("ret_rsp_rd", 1'b0, 16'h6000, 16'h0000, e_rsp_rd());
    cyc("ret_jmp", 1'b0, 16'h6000, 16'h0000, e_ret());
    // ALU aborted by reset during POPB_RD
    cyc("abort_fetch", 1'b0, 16'h2001, 16'h0000, e_fetch());
    cyc("abort_decode", 1'b0, 16'h2001, 16'h0000, e_zero());
    cyc("abort_popa_dec", 1'b0, 16'h2001, 16'h0000, e_msp_pop());
    cyc("abort_popa_rd", 1'b0, 16'h2001, 16'h0000, e_rd(1'b0));
    cyc("abort_popb_dec", 1'b0, 16'h2001, 16'h0000, e_msp_pop());
    cyc("abort_popb_rd_rst", 1'b1, 16'h2001, 16'h0000, e_zero());
    cyc("abort_rst", 1'b0, 16'h2001, 16'h0000, e_rst());
    // Illegal opcode
    cyc("ill_fetch", 1'b0, 16'h7000, 16'h0000, e_fetch());
    cyc("ill_decode", 1'b0, 16'h7000, 16'h0000, e_zero());
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_halt0", 1'b0, 16'h7000, 16'h0000, e_halt(1'b1));
    cyc("ill_halt1", 1'b0, 16'h7000, 16'h0000, e_halt(1'b1));
    cyc("ill_halt_rst", 1'b1, 16'h7000, 16'h0000, e_halt(1'b1));
    cyc("ill_rst", 1'b0, 16'h7000, 16'h0000, e_rst());
`endif
    // HALT holds until reset; IllegalOp stays low for a legal HALT
    cyc("halt_fetch", 1'b0, 16'hF000, 16'h0000, e_fetch());
    cyc("halt_decode", 1'b0, 16'hF000, 16'h0000, e_zero());
    cyc("halt0", 1'b0, 16'hF000, 16'h0000, e_halt(1'b0));
    cyc("halt1", 1'b0, 16'hF000, 16'h0000, e_halt(1'b0));
    cyc("halt2", 1'b0, 16'hF000, 16'h0000, e_halt(1'b0));
    cyc("halt_rst", 1'b1, 16'hF000, 16'h0000, e_halt(1'b0));
    cyc("halt_rst_state", 1'b0, 16'hF000, 16'h0000, e_rst());
    cyc("post_fetch", 1'b0, 16'h0000, 16'h0000, e_fetch());
    cyc("post_decode", 1'b0, 16'h0000, 16'h0000, e_zero());

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
